// File: rtl/axi_ram_arb_pkg.sv
// Shared types and the round-robin pick function for the two-master AXI RAM arbiter.
package axi_ram_arb_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rstate_t;

   // last = master that won the previous burst; a tie goes to the other one.
   function automatic logic next_grant(input logic [1:0] req, input logic last);
      if (req == 2'b11) return ~last;
      return req[1];
   endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-requester round-robin picker: grant is captured on load, and priority
// moves to the other requester on update (end of the granted burst).
module axi_rr_arb2
   import axi_ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       load,
   input  logic       update,
   output logic       grant
);

   logic prio;  // requester that wins the next tie

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio  <= 1'b0;
         grant <= 1'b0;
      end else begin
         if (load)   grant <= next_grant(req, ~prio);
         if (update) prio  <= ~grant;
      end
   end

endmodule

// File: rtl/axi_ram_arb2.sv
// Two-master to one-slave AXI4 arbiter in front of a shared RAM; independent
// read and write round-robin, grant held for a whole burst, data paths combinational.
module axi_ram_arb2
   import axi_ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int ID_WIDTH   = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   // master 0
   input  logic [ID_WIDTH-1:0]   s0_axi_awid_i,
   input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr_i,
   input  logic [LEN_WIDTH-1:0]  s0_axi_awlen_i,
   input  logic [2:0]            s0_axi_awsize_i,
   input  logic [1:0]            s0_axi_awburst_i,
   input  logic                  s0_axi_awvalid_i,
   output logic                  s0_axi_awready_o,
   input  logic [DATA_WIDTH-1:0] s0_axi_wdata_i,
   input  logic [STRB_WIDTH-1:0] s0_axi_wstrb_i,
   input  logic                  s0_axi_wlast_i,
   input  logic                  s0_axi_wvalid_i,
   output logic                  s0_axi_wready_o,
   output logic [ID_WIDTH-1:0]   s0_axi_bid_o,
   output logic [1:0]            s0_axi_bresp_o,
   output logic                  s0_axi_bvalid_o,
   input  logic                  s0_axi_bready_i,
   input  logic [ID_WIDTH-1:0]   s0_axi_arid_i,
   input  logic [ADDR_WIDTH-1:0] s0_axi_araddr_i,
   input  logic [LEN_WIDTH-1:0]  s0_axi_arlen_i,
   input  logic [2:0]            s0_axi_arsize_i,
   input  logic [1:0]            s0_axi_arburst_i,
   input  logic                  s0_axi_arvalid_i,
   output logic                  s0_axi_arready_o,
   output logic [ID_WIDTH-1:0]   s0_axi_rid_o,
   output logic [DATA_WIDTH-1:0] s0_axi_rdata_o,
   output logic [1:0]            s0_axi_rresp_o,
   output logic                  s0_axi_rlast_o,
   output logic                  s0_axi_rvalid_o,
   input  logic                  s0_axi_rready_i,
   // master 1
   input  logic [ID_WIDTH-1:0]   s1_axi_awid_i,
   input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr_i,
   input  logic [LEN_WIDTH-1:0]  s1_axi_awlen_i,
   input  logic [2:0]            s1_axi_awsize_i,
   input  logic [1:0]            s1_axi_awburst_i,
   input  logic                  s1_axi_awvalid_i,
   output logic                  s1_axi_awready_o,
   input  logic [DATA_WIDTH-1:0] s1_axi_wdata_i,
   input  logic [STRB_WIDTH-1:0] s1_axi_wstrb_i,
   input  logic                  s1_axi_wlast_i,
   input  logic                  s1_axi_wvalid_i,
   output logic                  s1_axi_wready_o,
   output logic [ID_WIDTH-1:0]   s1_axi_bid_o,
   output logic [1:0]            s1_axi_bresp_o,
   output logic                  s1_axi_bvalid_o,
   input  logic                  s1_axi_bready_i,
   input  logic [ID_WIDTH-1:0]   s1_axi_arid_i,
   input  logic [ADDR_WIDTH-1:0] s1_axi_araddr_i,
   input  logic [LEN_WIDTH-1:0]  s1_axi_arlen_i,
   input  logic [2:0]            s1_axi_arsize_i,
   input  logic [1:0]            s1_axi_arburst_i,
   input  logic                  s1_axi_arvalid_i,
   output logic                  s1_axi_arready_o,
   output logic [ID_WIDTH-1:0]   s1_axi_rid_o,
   output logic [DATA_WIDTH-1:0] s1_axi_rdata_o,
   output logic [1:0]            s1_axi_rresp_o,
   output logic                  s1_axi_rlast_o,
   output logic                  s1_axi_rvalid_o,
   input  logic                  s1_axi_rready_i,
   // toward the RAM
   output logic [ID_WIDTH-1:0]   m_axi_awid_o,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
   output logic [LEN_WIDTH-1:0]  m_axi_awlen_o,
   output logic [2:0]            m_axi_awsize_o,
   output logic [1:0]            m_axi_awburst_o,
   output logic                  m_axi_awlock_o,
   output logic [3:0]            m_axi_awcache_o,
   output logic [2:0]            m_axi_awprot_o,
   output logic [3:0]            m_axi_awqos_o,
   output logic                  m_axi_awvalid_o,
   input  logic                  m_axi_awready_i,
   output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,
   output logic                  m_axi_wlast_o,
   output logic                  m_axi_wvalid_o,
   input  logic                  m_axi_wready_i,
   input  logic [ID_WIDTH-1:0]   m_axi_bid_i,
   input  logic [1:0]            m_axi_bresp_i,
   input  logic                  m_axi_bvalid_i,
   output logic                  m_axi_bready_o,
   output logic [ID_WIDTH-1:0]   m_axi_arid_o,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
   output logic [LEN_WIDTH-1:0]  m_axi_arlen_o,
   output logic [2:0]            m_axi_arsize_o,
   output logic [1:0]            m_axi_arburst_o,
   output logic                  m_axi_arlock_o,
   output logic [3:0]            m_axi_arcache_o,
   output logic [2:0]            m_axi_arprot_o,
   output logic [3:0]            m_axi_arqos_o,
   output logic                  m_axi_arvalid_o,
   input  logic                  m_axi_arready_i,
   input  logic [ID_WIDTH-1:0]   m_axi_rid_i,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
   input  logic [1:0]            m_axi_rresp_i,
   input  logic                  m_axi_rlast_i,
   input  logic                  m_axi_rvalid_i,
   output logic                  m_axi_rready_o
);

   wstate_t wstate, wstate_nx;
   rstate_t rstate, rstate_nx;
   logic    wg, rg, wload, wupd, rload, rupd;
   logic    w_addr, w_data, w_resp, r_addr, r_data;

   axi_rr_arb2 u_warb (.clk(clk_i), .rst_n(arst_n_i), .req({s1_axi_awvalid_i, s0_axi_awvalid_i}),
                       .load(wload), .update(wupd), .grant(wg));
   axi_rr_arb2 u_rarb (.clk(clk_i), .rst_n(arst_n_i), .req({s1_axi_arvalid_i, s0_axi_arvalid_i}),
                       .load(rload), .update(rupd), .grant(rg));

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wstate <= W_IDLE;
         rstate <= R_IDLE;
      end else begin
         wstate <= wstate_nx;
         rstate <= rstate_nx;
      end
   end

   always_comb begin
      wstate_nx = wstate;
      wload     = 1'b0;
      wupd      = 1'b0;
      case (wstate)
         W_IDLE: if (s0_axi_awvalid_i || s1_axi_awvalid_i) begin
            wload     = 1'b1;
            wstate_nx = W_ADDR;
         end
         W_ADDR: if (m_axi_awvalid_o && m_axi_awready_i) wstate_nx = W_DATA;
         W_DATA: if (m_axi_wvalid_o && m_axi_wready_i && m_axi_wlast_o) wstate_nx = W_RESP;
         W_RESP: if (m_axi_bvalid_i && m_axi_bready_o) begin
            wupd      = 1'b1;
            wstate_nx = W_IDLE;
         end
         default: wstate_nx = W_IDLE;
      endcase
   end

   always_comb begin
      rstate_nx = rstate;
      rload     = 1'b0;
      rupd      = 1'b0;
      case (rstate)
         R_IDLE: if (s0_axi_arvalid_i || s1_axi_arvalid_i) begin
            rload     = 1'b1;
            rstate_nx = R_ADDR;
         end
         R_ADDR: if (m_axi_arvalid_o && m_axi_arready_i) rstate_nx = R_DATA;
         R_DATA: if (m_axi_rvalid_i && m_axi_rready_o && m_axi_rlast_i) begin
            rupd      = 1'b1;
            rstate_nx = R_IDLE;
         end
         default: rstate_nx = R_IDLE;
      endcase
   end

   assign w_addr = (wstate == W_ADDR);
   assign w_data = (wstate == W_DATA);
   assign w_resp = (wstate == W_RESP);
   assign r_addr = (rstate == R_ADDR);
   assign r_data = (rstate == R_DATA);

   // Payload fields follow the grant unconditionally; only valid/ready are phase-gated.
   assign m_axi_awid_o     = wg ? s1_axi_awid_i    : s0_axi_awid_i;
   assign m_axi_awaddr_o   = wg ? s1_axi_awaddr_i  : s0_axi_awaddr_i;
   assign m_axi_awlen_o    = wg ? s1_axi_awlen_i   : s0_axi_awlen_i;
   assign m_axi_awsize_o   = wg ? s1_axi_awsize_i  : s0_axi_awsize_i;
   assign m_axi_awburst_o  = wg ? s1_axi_awburst_i : s0_axi_awburst_i;
   assign m_axi_awvalid_o  = w_addr && (wg ? s1_axi_awvalid_i : s0_axi_awvalid_i);
   assign s0_axi_awready_o = w_addr && !wg && m_axi_awready_i;
   assign s1_axi_awready_o = w_addr &&  wg && m_axi_awready_i;

   assign m_axi_wdata_o    = wg ? s1_axi_wdata_i : s0_axi_wdata_i;
   assign m_axi_wstrb_o    = wg ? s1_axi_wstrb_i : s0_axi_wstrb_i;
   assign m_axi_wlast_o    = wg ? s1_axi_wlast_i : s0_axi_wlast_i;
   assign m_axi_wvalid_o   = w_data && (wg ? s1_axi_wvalid_i : s0_axi_wvalid_i);
   assign s0_axi_wready_o  = w_data && !wg && m_axi_wready_i;
   assign s1_axi_wready_o  = w_data &&  wg && m_axi_wready_i;

   assign s0_axi_bid_o     = m_axi_bid_i;
   assign s1_axi_bid_o     = m_axi_bid_i;
   assign s0_axi_bresp_o   = m_axi_bresp_i;
   assign s1_axi_bresp_o   = m_axi_bresp_i;
   assign s0_axi_bvalid_o  = w_resp && !wg && m_axi_bvalid_i;
   assign s1_axi_bvalid_o  = w_resp &&  wg && m_axi_bvalid_i;
   assign m_axi_bready_o   = w_resp && (wg ? s1_axi_bready_i : s0_axi_bready_i);

   assign m_axi_arid_o     = rg ? s1_axi_arid_i    : s0_axi_arid_i;
   assign m_axi_araddr_o   = rg ? s1_axi_araddr_i  : s0_axi_araddr_i;
   assign m_axi_arlen_o    = rg ? s1_axi_arlen_i   : s0_axi_arlen_i;
   assign m_axi_arsize_o   = rg ? s1_axi_arsize_i  : s0_axi_arsize_i;
   assign m_axi_arburst_o  = rg ? s1_axi_arburst_i : s0_axi_arburst_i;
   assign m_axi_arvalid_o  = r_addr && (rg ? s1_axi_arvalid_i : s0_axi_arvalid_i);
   assign s0_axi_arready_o = r_addr && !rg && m_axi_arready_i;
   assign s1_axi_arready_o = r_addr &&  rg && m_axi_arready_i;

   assign s0_axi_rid_o     = m_axi_rid_i;
   assign s1_axi_rid_o     = m_axi_rid_i;
   assign s0_axi_rdata_o   = m_axi_rdata_i;
   assign s1_axi_rdata_o   = m_axi_rdata_i;
   assign s0_axi_rresp_o   = m_axi_rresp_i;
   assign s1_axi_rresp_o   = m_axi_rresp_i;
   assign s0_axi_rlast_o   = m_axi_rlast_i;
   assign s1_axi_rlast_o   = m_axi_rlast_i;
   assign s0_axi_rvalid_o  = r_data && !rg && m_axi_rvalid_i;
   assign s1_axi_rvalid_o  = r_data &&  rg && m_axi_rvalid_i;
   assign m_axi_rready_o   = r_data && (rg ? s1_axi_rready_i : s0_axi_rready_i);

   assign m_axi_awlock_o   = 1'b0;
   assign m_axi_awcache_o  = 4'd0;
   assign m_axi_awprot_o   = 3'd0;
   assign m_axi_awqos_o    = 4'd0;
   assign m_axi_arlock_o   = 1'b0;
   assign m_axi_arcache_o  = 4'd0;
   assign m_axi_arprot_o   = 3'd0;
   assign m_axi_arqos_o    = 4'd0;

endmodule

// File: tb/tb_axi_ram_arb2.sv
// Directed bench for axi_ram_arb2 with a simple behavioural AXI RAM on the m side.
module tb_axi_ram_arb2;

   logic clk = 1'b0;
   logic arst_n;
   always #5 clk = ~clk;

   // master-side signals, index = master number
   logic [1:0][7:0]  awid, arid, bid, rid, awlen, arlen;
   logic [1:0][15:0] awaddr, araddr;
   logic [1:0][31:0] wdata, rdata;
   logic [1:0][1:0]  bresp, rresp;
   logic [1:0]       awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [1:0]       arvalid, arready, rlast, rvalid, rready;

   // RAM-side signals
   logic [7:0]  m_awid, m_arid, m_awlen, m_arlen, m_bid, m_rid;
   logic [15:0] m_awaddr, m_araddr;
   logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
   logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
   logic [3:0]  m_awcache, m_arcache, m_awqos, m_arqos, m_wstrb;
   logic        m_awlock, m_arlock;
   logic [31:0] m_wdata, m_rdata;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;

   int n_chk = 0, n_fail = 0;

   axi_ram_arb2 dut (
      .clk_i(clk), .arst_n_i(arst_n),
      .s0_axi_awid_i(awid[0]), .s0_axi_awaddr_i(awaddr[0]), .s0_axi_awlen_i(awlen[0]),
      .s0_axi_awsize_i(3'd2), .s0_axi_awburst_i(2'b01), .s0_axi_awvalid_i(awvalid[0]), .s0_axi_awready_o(awready[0]),
      .s0_axi_wdata_i(wdata[0]), .s0_axi_wstrb_i(4'hF), .s0_axi_wlast_i(wlast[0]),
      .s0_axi_wvalid_i(wvalid[0]), .s0_axi_wready_o(wready[0]),
      .s0_axi_bid_o(bid[0]), .s0_axi_bresp_o(bresp[0]), .s0_axi_bvalid_o(bvalid[0]), .s0_axi_bready_i(bready[0]),
      .s0_axi_arid_i(arid[0]), .s0_axi_araddr_i(araddr[0]), .s0_axi_arlen_i(arlen[0]),
      .s0_axi_arsize_i(3'd2), .s0_axi_arburst_i(2'b01), .s0_axi_arvalid_i(arvalid[0]), .s0_axi_arready_o(arready[0]),
      .s0_axi_rid_o(rid[0]), .s0_axi_rdata_o(rdata[0]), .s0_axi_rresp_o(rresp[0]), .s0_axi_rlast_o(rlast[0]),
      .s0_axi_rvalid_o(rvalid[0]), .s0_axi_rready_i(rready[0]),
      .s1_axi_awid_i(awid[1]), .s1_axi_awaddr_i(awaddr[1]), .s1_axi_awlen_i(awlen[1]),
      .s1_axi_awsize_i(3'd2), .s1_axi_awburst_i(2'b01), .s1_axi_awvalid_i(awvalid[1]), .s1_axi_awready_o(awready[1]),
      .s1_axi_wdata_i(wdata[1]), .s1_axi_wstrb_i(4'hF), .s1_axi_wlast_i(wlast[1]),
      .s1_axi_wvalid_i(wvalid[1]), .s1_axi_wready_o(wready[1]),
      .s1_axi_bid_o(bid[1]), .s1_axi_bresp_o(bresp[1]), .s1_axi_bvalid_o(bvalid[1]), .s1_axi_bready_i(bready[1]),
      .s1_axi_arid_i(arid[1]), .s1_axi_araddr_i(araddr[1]), .s1_axi_arlen_i(arlen[1]),
      .s1_axi_arsize_i(3'd2), .s1_axi_arburst_i(2'b01), .s1_axi_arvalid_i(arvalid[1]), .s1_axi_arready_o(arready[1]),
      .s1_axi_rid_o(rid[1]), .s1_axi_rdata_o(rdata[1]), .s1_axi_rresp_o(rresp[1]), .s1_axi_rlast_o(rlast[1]),
      .s1_axi_rvalid_o(rvalid[1]), .s1_axi_rready_i(rready[1]),
      .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen), .m_axi_awsize_o(m_awsize),
      .m_axi_awburst_o(m_awburst), .m_axi_awlock_o(m_awlock), .m_axi_awcache_o(m_awcache),
      .m_axi_awprot_o(m_awprot), .m_axi_awqos_o(m_awqos), .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
      .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
      .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
      .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
      .m_axi_arid_o(m_arid), .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen), .m_axi_arsize_o(m_arsize),
      .m_axi_arburst_o(m_arburst), .m_axi_arlock_o(m_arlock), .m_axi_arcache_o(m_arcache),
      .m_axi_arprot_o(m_arprot), .m_axi_arqos_o(m_arqos), .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
      .m_axi_rid_i(m_rid), .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
      .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready)
   );

   // Behavioural RAM: 256 words, one write and one read burst in flight at a time.
   logic [31:0] mem [0:255];
   logic        wbusy, bpend, rbusy;
   logic [7:0]  wa, ra, rcnt, rlen_q, wid_q, rid_q;

   assign m_awready = ~wbusy;
   assign m_wready  = wbusy & ~bpend;
   assign m_bvalid  = bpend;
   assign m_bid     = wid_q;
   assign m_bresp   = 2'b00;
   assign m_arready = ~rbusy;
   assign m_rvalid  = rbusy;
   assign m_rdata   = mem[ra];
   assign m_rlast   = (rcnt == rlen_q);
   assign m_rid     = rid_q;
   assign m_rresp   = 2'b00;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wbusy <= 1'b0; bpend <= 1'b0; rbusy <= 1'b0;
         wa <= 8'd0; ra <= 8'd0; rcnt <= 8'd0; rlen_q <= 8'd0; wid_q <= 8'd0; rid_q <= 8'd0;
         for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD0000 | 32'(i);
      end else begin
         if (m_awvalid && m_awready) begin wbusy <= 1'b1; wa <= m_awaddr[9:2]; wid_q <= m_awid; end
         if (m_wvalid && m_wready) begin
            mem[wa] <= m_wdata;
            wa <= wa + 8'd1;
            if (m_wlast) bpend <= 1'b1;
         end
         if (m_bvalid && m_bready) begin bpend <= 1'b0; wbusy <= 1'b0; end
         if (m_arvalid && m_arready) begin
            rbusy <= 1'b1; ra <= m_araddr[9:2]; rlen_q <= m_arlen; rcnt <= 8'd0; rid_q <= m_arid;
         end
         if (m_rvalid && m_rready) begin
            ra <= ra + 8'd1;
            rcnt <= rcnt + 8'd1;
            if (m_rlast) rbusy <= 1'b0;
         end
      end
   end

   // AW grant order as seen at the RAM
   logic [7:0] aw_log [$];
   always @(posedge clk) if (m_awvalid && m_awready) aw_log.push_back(m_awid);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int m, input int ch);
      case (ch)
         0:       return awready[m];
         1:       return wready[m];
         2:       return bvalid[m];
         default: return arready[m];
      endcase
   endfunction

   function automatic logic s_any(input int m);
      return awready[m] | wready[m] | bvalid[m] | arready[m] | rvalid[m];
   endfunction

   // Waits (bounded) until the handshake condition is visible; the handshake
   // itself happens on the following posedge.
   task automatic wait_rdy(input int m, input int ch, input string tag);
      int n = 0;
      #1;
      while (!rdy(m, ch) && n < 500) begin
         @(negedge clk); #1; n++;
      end
      chk(tag, 64'(rdy(m, ch)), 64'd1);
   endtask

   task automatic wr_burst(input int m, input logic [7:0] id, input logic [15:0] addr,
                           input int len, input logic [31:0] d0);
      awid[m] = id; awaddr[m] = addr; awlen[m] = 8'(len); awvalid[m] = 1'b1;
      wait_rdy(m, 0, "aw_hs");
      @(negedge clk);
      awvalid[m] = 1'b0;
      for (int b = 0; b <= len; b++) begin
         wdata[m] = d0 + 32'(b); wlast[m] = (b == len); wvalid[m] = 1'b1;
         wait_rdy(m, 1, "w_hs");
         chk("w_pass", {m_wvalid, m_wlast, m_wdata}, {1'b1, b == len, d0 + 32'(b)});
         @(negedge clk);
      end
      wvalid[m] = 1'b0; wlast[m] = 1'b0; bready[m] = 1'b1;
      wait_rdy(m, 2, "b_hs");
      chk("bid", 64'(bid[m]), 64'(id));
      @(negedge clk);
      bready[m] = 1'b0;
   endtask

   task automatic rd_burst(input int m, input logic [7:0] id, input logic [15:0] addr,
                           input int len, input logic [31:0] d0, input bit bp);
      int beat = 0;
      int cyc = 0;
      logic [3:0] pat = 4'b1001;  // rready per cycle: 1,0,0,1
      arid[m] = id; araddr[m] = addr; arlen[m] = 8'(len); arvalid[m] = 1'b1;
      wait_rdy(m, 3, "ar_hs");
      @(negedge clk);
      arvalid[m] = 1'b0;
      while (beat <= len && cyc < 500) begin
         rready[m] = bp ? pat[cyc % 4] : 1'b1;
         #1;
         if (rvalid[m] && rready[m]) begin
            chk("r_data", 64'(rdata[m]), 64'(d0 + 32'(beat)));
            chk("r_last", 64'(rlast[m]), 64'(beat == len));
            chk("r_id", 64'(rid[m]), 64'(id));
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      rready[m] = 1'b0;
      chk("r_beats", 64'(beat), 64'(len + 1));
   endtask

   bit stop;
   int bad;
   int n0;

   initial begin
      arst_n = 1'b0;
      awid = '0; arid = '0; awlen = '0; arlen = '0; awaddr = '0; araddr = '0; wdata = '0;
      awvalid = '0; wlast = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_s_out", {awready, wready, bvalid, arready, rvalid}, 64'd0);
      chk("rst_m_out", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);

      // fairness: both masters keep requesting, two bursts each
      n0 = aw_log.size();
      fork
         begin wr_burst(0, 8'd1, 16'h100, 1, 32'h100); wr_burst(0, 8'd1, 16'h110, 1, 32'h110); end
         begin wr_burst(1, 8'd2, 16'h200, 1, 32'h200); wr_burst(1, 8'd2, 16'h210, 1, 32'h210); end
      join
      chk("rr_cnt", 64'(aw_log.size() - n0), 64'd4);
      if (aw_log.size() - n0 >= 4)
         chk("rr_order", {aw_log[n0], aw_log[n0+1], aw_log[n0+2], aw_log[n0+3]}, 64'h01020102);
      rd_burst(0, 8'd1, 16'h100, 1, 32'h100, 1'b0);
      rd_burst(0, 8'd1, 16'h110, 1, 32'h110, 1'b0);
      rd_burst(1, 8'd2, 16'h200, 1, 32'h200, 1'b0);
      rd_burst(1, 8'd2, 16'h210, 1, 32'h210, 1'b0);

      // single s0 write with early W data; s1 must stay quiet
      @(negedge clk);
      awid[0] = 8'd5; awaddr[0] = 16'h10; awlen[0] = 8'd3; awvalid[0] = 1'b1;
      wdata[0] = 32'hA0; wvalid[0] = 1'b1;
      #1;
      chk("aw_lat0", 64'(m_awvalid), 64'd0);
      chk("early_w0", 64'(wready[0]), 64'd0);
      @(negedge clk); #1;
      chk("aw_lat1", {m_awvalid, m_awaddr}, {1'b1, 16'h10});
      chk("early_w1", 64'(wready[0]), 64'd0);
      stop = 1'b0; bad = 0;
      fork
         begin wr_burst(0, 8'd5, 16'h10, 3, 32'hA0); stop = 1'b1; end
         while (!stop) begin @(negedge clk); #2; if (s_any(1)) bad++; end
      join
      chk("s1_quiet", 64'(bad), 64'd0);

      // concurrent s0 read and s1 write
      fork
         rd_burst(0, 8'd3, 16'h40, 7, 32'hDEAD0010, 1'b0);
         wr_burst(1, 8'd7, 16'h80, 7, 32'hC0);
      join
      #1;
      chk("s1_one_b", 64'(bvalid[1]), 64'd0);

      // s1 read under rready backpressure; s0 must see no rvalid
      stop = 1'b0; bad = 0;
      fork
         begin rd_burst(1, 8'd8, 16'h80, 7, 32'hC0, 1'b1); stop = 1'b1; end
         while (!stop) begin @(negedge clk); #2; if (rvalid[0]) bad++; end
      join
      chk("s0_no_rvalid", 64'(bad), 64'd0);

      // leave both RR pointers pointing at s1 before the reset test
      rd_burst(0, 8'd4, 16'h10, 3, 32'hA0, 1'b0);
      wr_burst(0, 8'd4, 16'h20, 0, 32'h55);

      // reset during beat 3 of a 16-beat s0 write
      @(negedge clk);
      awid[0] = 8'd9; awaddr[0] = 16'h300; awlen[0] = 8'd15; awvalid[0] = 1'b1;
      wait_rdy(0, 0, "rst_aw");
      @(negedge clk);
      awvalid[0] = 1'b0;
      for (int b = 0; b < 3; b++) begin
         wdata[0] = 32'(b); wvalid[0] = 1'b1;
         wait_rdy(0, 1, "rst_w");
         @(negedge clk);
      end
      wdata[0] = 32'd3;
      #1;
      chk("rst_pre_wready", 64'(wready[0]), 64'd1);
      arst_n = 1'b0;
      #1;
      chk("rst_mid_s", {awready, wready, bvalid, arready, rvalid}, 64'd0);
      chk("rst_mid_m", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
      wvalid[0] = 1'b0;
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      chk("rst_idle", {m_awvalid, m_arvalid}, 64'd0);
      @(negedge clk);
      awid = {8'd10, 8'd9}; arid = {8'd10, 8'd9};
      awvalid = 2'b11; arvalid = 2'b11;
      #1;
      chk("tie_lat0", {m_awvalid, m_arvalid}, 64'd0);
      @(negedge clk); #1;
      chk("tie_aw", {m_awvalid, m_awid, awready}, {1'b1, 8'd9, 2'b01});
      chk("tie_ar", {m_arvalid, m_arid, arready}, {1'b1, 8'd9, 2'b01});
      awvalid = 2'b00; arvalid = 2'b00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_ram_arb2.md
Name: axi_ram_arb2

Overview:
- Two-master to one-slave AXI4 arbiter that shares a single axi_ram instance between two requesters, for example a CPU data port and a DMA engine.
- Read and write paths are arbitrated independently with round-robin priority.
- A grant is held for a whole burst: from the AR/AW handshake through the last R beat, or through the B handshake.
- Data, valid and ready pass through combinationally for the granted master. The only added latency is one registered arbitration cycle per burst.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
ID_WIDTH, 8, AXI ID width, passed through unchanged
LEN_WIDTH, 8, AXI burst length field width

Ports:
clk_i  input  1  clock
arst_n_i  input  1  asynchronous active-low reset
s0_axi_aw{id,addr,len,size,burst,valid}_i / s0_axi_awready_o  in/out  per AXI  master 0 write address channel
s0_axi_w{data,strb,last,valid}_i / s0_axi_wready_o  in/out  per AXI  master 0 write data channel
s0_axi_b{id,resp,valid}_o / s0_axi_bready_i  out/in  per AXI  master 0 write response channel
s0_axi_ar{id,addr,len,size,burst,valid}_i / s0_axi_arready_o  in/out  per AXI  master 0 read address channel
s0_axi_r{id,data,resp,last,valid}_o / s0_axi_rready_i  out/in  per AXI  master 0 read data channel
s1_axi_*  same set as s0  -  master 1
m_axi_*  mirror of the s0 set  -  toward the RAM
- m_axi_{aw,ar}{lock,cache,prot,qos}_o are tied to 0.

Behaviour:
- Reset state:
  - All *_ready_o and m_axi_*valid_o are 0.
  - Both FSMs are IDLE.
  - Round-robin pointers are 0, so master 0 wins the first tie.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: if any s*_awvalid_i is high, register wgrant. If both are high, grant the master that did not win last; if only one is high, grant it. Then go to W_ADDR. No ready is asserted in W_IDLE.
  - W_ADDR: m_axi_aw* = granted s*_aw*, and the granted awready_o = m_axi_awready_i. On the AW handshake, go to W_DATA.
  - W_DATA: m_axi_w* = granted s*_w*, and the granted wready_o = m_axi_wready_i. On a handshake with wlast=1, go to W_RESP. The beat count is not checked; wlast alone terminates the burst.
  - W_RESP: route m_axi_b* to the granted master, and m_axi_bready_o = granted bready_i. On the B handshake, toggle the write RR pointer to the other master and return to W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - Arbitration and address phase work the same way as on the write side, with its own independent RR pointer.
  - R_DATA: route m_axi_r* to the granted master. On a handshake with m_axi_rlast_i=1, update the pointer and return to R_IDLE.
- Non-granted master:
  - All of its ready outputs and valid outputs are held at 0.
  - Its rdata/bid outputs mirror m_axi but are qualified by valid=0.
- Latency:
  - One cycle from awvalid/arvalid to m_axi_awvalid_o/arvalid_o.
  - Zero cycles on every routed beat.
  - Back-to-back bursts lose one IDLE cycle each.
- Concurrency:
  - A read of master 0 and a write of master 1, or the reverse, proceed simultaneously.
  - The RAM serializes them internally.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1 per burst.
- Early W data: W beats that arrive before their AW grant are stalled (wready=0) until W_DATA.
- A master dropping awvalid/arvalid after the grant violates AXI. The behaviour in that case is undefined, with no recovery logic.
- Reset mid-burst:
  - Asserting arst_n_i=0 immediately forces IDLE and all valid/ready outputs to 0.
  - The in-flight burst is abandoned.
  - The RAM must be reset by the same (inverted) reset.
- All FSM and grant registers use async active-low reset. There are no other storage elements.

Decomposition:
- Package axi_ram_arb_pkg:
  - write FSM state encoding (2 bits)
  - read FSM state encoding (2 bits)
  - RR pointer helper function next_grant(req[1:0], last)
- Natural sub-module: axi_rr_arb2, a 2-requester round-robin picker with a registered pointer and an update strobe. It is instantiated once for reads and once for writes.
- Channel muxing stays in the top module.

Test Plan:
- Single master-0 write, awaddr=0x10, awlen=3, data 0xA0..0xA3:
  - m_axi_awvalid_o rises 1 cycle after s0_axi_awvalid_i.
  - Four W beats pass with zero added latency.
  - s0 gets bvalid with bid equal to awid.
  - s1 ready/valid stay 0 throughout.
- Simultaneous awvalid from s0 (id 1) and s1 (id 2), each with len 1, then repeated:
  - Grant order is s0, s1, s0, s1.
  - The RAM read-back shows each master's data at its own address.
- Concurrent s0 read (araddr=0x40, len 7) and s1 write (awaddr=0x80, len 7):
  - Both bursts complete.
  - s0 receives 8 beats with rlast only on beat 8.
  - s1 receives one B response.
- Backpressure: s1 read with rready toggling 1,0,0,1 per cycle:
  - The R beat sequence is unchanged and no beat is duplicated or lost.
  - s0_axi_rvalid_o stays 0.
- Reset: assert arst_n_i=0 during beat 3 of a 16-beat s0 write, then release:
  - All valid/ready outputs go to 0 within the same cycle.
  - After release, both FSMs are IDLE and the first tied request goes to s0.
